// File: rtl/core_pkg.sv
// Shared RV32I front-end definitions: next-PC select codes, bubble word, decode slices, fetch FSM states.
package core_pkg;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;
  localparam logic [1:0] PCSRC_NEXT = 2'b11;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int OPC_HI = 6;
  localparam int OPC_LO = 2;
  localparam int IMMBIT = 20;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  function automatic logic [4:0] opcode_of(input logic [31:0] inst);
    return inst[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: imem bus, IF/ID outputs, decoder controls and EX redirect inputs.
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            resume;
  logic [1:0]      ex_srcPC;
  logic            ex_branch_taken;
  logic            ex_flush;
  logic            ex_pcload;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic [XLEN-1:0] ex_alu_result;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [XLEN-1:0] ifid_pc;
  logic [31:0]     ifid_inst;
  logic            ifid_valid;
  logic [4:0]      ctrl_opcode;
  logic            ctrl_immbit;
  logic            kill_idex;
  logic            halted;

  modport master (
    input  stall, resume, ex_srcPC, ex_branch_taken, ex_flush, ex_pcload,
           ex_pc, ex_target, ex_alu_result, imem_rdata,
    output imem_addr, ifid_pc, ifid_inst, ifid_valid, ctrl_opcode, ctrl_immbit,
           kill_idex, halted
  );

  modport slave (
    output stall, resume, ex_srcPC, ex_branch_taken, ex_flush, ex_pcload,
           ex_pc, ex_target, ex_alu_result, imem_rdata,
    input  imem_addr, ifid_pc, ifid_inst, ifid_valid, ctrl_opcode, ctrl_immbit,
           kill_idex, halted
  );
endinterface

// File: rtl/fetch_stage_next_pc_sel.sv
// Combinational redirect detect and target mux for the EX-stage instruction; target is word aligned.
module next_pc_sel
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      src_pc,
  input  logic            branch_taken,
  input  logic            flush,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] ex_alu_result,
  output logic            redirect,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] raw_target;

  always_comb begin
    raw_target = ex_pc + XLEN'(4);
    case (src_pc)
      PCSRC_BR:   raw_target = ex_target;
      PCSRC_JALR: raw_target = ex_alu_result & ~XLEN'(1);
      default:    raw_target = ex_pc + XLEN'(4);
    endcase
  end

  // Misaligned targets are not trapped; the low bits are simply dropped.
  assign target   = raw_target & ~XLEN'(3);
  assign redirect = flush | ((src_pc == PCSRC_BR) & branch_taken);

endmodule

// File: rtl/fetch_stage.sv
// RV32I program counter and IF/ID register with redirect, stall and ebreak halt/resume handling.
module fetch_stage #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0,
  parameter logic [31:0]       NOP_INST = core_pkg::NOP_INST
) (
  input logic         clk,
  input logic         rst,
  fetch_stage_if.master bus
);
  import core_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_inst_q, ifid_inst_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] halt_pc_q, halt_pc_d;
  logic            kill;
  logic            redirect;
  logic [XLEN-1:0] target;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .src_pc        (bus.ex_srcPC),
    .branch_taken  (bus.ex_branch_taken),
    .flush         (bus.ex_flush),
    .ex_pc         (bus.ex_pc),
    .ex_target     (bus.ex_target),
    .ex_alu_result (bus.ex_alu_result),
    .redirect      (redirect),
    .target        (target)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    halt_pc_d    = halt_pc_q;
    kill         = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.ex_pcload) begin
          state_d      = HALT;
          ifid_pc_d    = '0;
          ifid_inst_d  = NOP_INST;
          ifid_valid_d = 1'b0;
          halt_pc_d    = bus.ex_pc;
          kill         = 1'b1;
        end else if (redirect) begin
          // A redirect discards whatever a concurrent stall was holding.
          pc_d         = target;
          ifid_pc_d    = '0;
          ifid_inst_d  = NOP_INST;
          ifid_valid_d = 1'b0;
          kill         = 1'b1;
        end else if (!bus.stall) begin
          pc_d         = pc_q + XLEN'(4);
          ifid_pc_d    = pc_q;
          ifid_inst_d  = bus.imem_rdata;
          ifid_valid_d = 1'b1;
        end
      end
      HALT: begin
        if (bus.resume) begin
          pc_d    = halt_pc_q + XLEN'(4);
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_inst_q  <= NOP_INST;
      ifid_valid_q <= 1'b0;
      halt_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
      halt_pc_q    <= halt_pc_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.ifid_pc     = ifid_pc_q;
  assign bus.ifid_inst   = ifid_inst_q;
  assign bus.ifid_valid  = ifid_valid_q;
  assign bus.ctrl_opcode = opcode_of(ifid_inst_q);
  assign bus.ctrl_immbit = ifid_inst_q[IMMBIT];
  assign bus.kill_idex   = kill;
  assign bus.halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed per-cycle vectors queued by stimulus, checked by a negedge monitor.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(32)) bus_a ();
  fetch_stage_if #(.XLEN(32)) bus_b ();

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign bus_a.imem_rdata = word(bus_a.imem_addr);
  assign bus_b.imem_rdata = word(bus_b.imem_addr);

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] inst;
    logic [31:0] bpc;
    logic        vld;
    logic        kill;
    logic        halt;
    logic        chk_ipc;
    logic        chk_b;
  } exp_t;

  exp_t sbq[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc_id       = 0;

  task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL c%0d %s: got %h expected %h", id, name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.id, "imem_addr",   bus_a.imem_addr,          e.pc);
      chk(e.id, "ifid_inst",   bus_a.ifid_inst,          e.inst);
      chk(e.id, "ifid_valid",  32'(bus_a.ifid_valid),    32'(e.vld));
      chk(e.id, "kill_idex",   32'(bus_a.kill_idex),     32'(e.kill));
      chk(e.id, "halted",      32'(bus_a.halted),        32'(e.halt));
      chk(e.id, "ctrl_opcode", 32'(bus_a.ctrl_opcode),   32'(e.inst[6:2]));
      chk(e.id, "ctrl_immbit", 32'(bus_a.ctrl_immbit),   32'(e.inst[20]));
      if (e.chk_ipc) chk(e.id, "ifid_pc", bus_a.ifid_pc, e.ipc);
      if (e.chk_b) chk(e.id, "wrap_pc", bus_b.imem_addr, e.bpc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus_a.stall           = 1'b0;
    bus_a.resume          = 1'b0;
    bus_a.ex_srcPC        = 2'b00;
    bus_a.ex_branch_taken = 1'b0;
    bus_a.ex_flush        = 1'b0;
    bus_a.ex_pcload       = 1'b0;
    bus_a.ex_pc           = '0;
    bus_a.ex_target       = '0;
    bus_a.ex_alu_result   = '0;
  endtask

  task automatic expect_cyc(input logic [31:0] pc, input logic [31:0] ipc, input logic [31:0] inst,
                            input logic vld, input logic kill, input logic halt, input logic chk_ipc,
                            input logic chk_b = 1'b0, input logic [31:0] bpc = 32'h0);
    exp_t e;
    e.id = cyc_id; e.pc = pc; e.ipc = ipc; e.inst = inst; e.bpc = bpc;
    e.vld = vld; e.kill = kill; e.halt = halt; e.chk_ipc = chk_ipc; e.chk_b = chk_b;
    sbq.push_back(e);
    cyc_id++;
  endtask

  initial begin
    bus_b.stall = 1'b0; bus_b.resume = 1'b0; bus_b.ex_srcPC = 2'b00;
    bus_b.ex_branch_taken = 1'b0; bus_b.ex_flush = 1'b0; bus_b.ex_pcload = 1'b0;
    bus_b.ex_pc = '0; bus_b.ex_target = '0; bus_b.ex_alu_result = '0;

    // reset state, then sequential fetch
    tick(); tick();
    rst = 1'b0;
    expect_cyc(32'h00, 32'h0, NOP, 0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    tick(); expect_cyc(32'h04, 32'h00, word(32'h00), 1, 0, 0, 1, 1, 32'h0);
    tick(); expect_cyc(32'h08, 32'h04, word(32'h04), 1, 0, 0, 1);
    tick(); expect_cyc(32'h0C, 32'h08, word(32'h08), 1, 0, 0, 1);

    // taken branch at pc 0x10, then an untaken one
    tick(); bus_a.ex_srcPC = 2'b01; bus_a.ex_branch_taken = 1'b1; bus_a.ex_target = 32'h40;
    expect_cyc(32'h10, 32'h0C, word(32'h0C), 1, 1, 0, 1);
    tick(); bus_a.ex_srcPC = 2'b01; bus_a.ex_branch_taken = 1'b0; bus_a.ex_target = 32'h80;
    expect_cyc(32'h40, 32'h0, NOP, 0, 0, 0, 0);
    tick(); expect_cyc(32'h44, 32'h40, word(32'h40), 1, 0, 0, 1);

    // jalr with odd rs1+imm
    tick(); bus_a.ex_flush = 1'b1; bus_a.ex_srcPC = 2'b10; bus_a.ex_alu_result = 32'h103;
    expect_cyc(32'h48, 32'h44, word(32'h44), 1, 1, 0, 1);
    tick(); expect_cyc(32'h100, 32'h0, NOP, 0, 0, 0, 0);

    // stall freezes, then redirect beats stall (misaligned target)
    tick(); bus_a.stall = 1'b1; expect_cyc(32'h104, 32'h100, word(32'h100), 1, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      tick(); bus_a.stall = 1'b1; expect_cyc(32'h104, 32'h100, word(32'h100), 1, 0, 0, 1);
    end
    tick(); bus_a.stall = 1'b1; bus_a.ex_flush = 1'b1; bus_a.ex_srcPC = 2'b01; bus_a.ex_target = 32'h82;
    expect_cyc(32'h104, 32'h100, word(32'h100), 1, 1, 0, 1);
    tick(); expect_cyc(32'h80, 32'h0, NOP, 0, 0, 0, 0);
    tick(); expect_cyc(32'h84, 32'h80, word(32'h80), 1, 0, 0, 1);

    // ebreak: halt, ignore everything for 5 cycles, resume
    tick(); bus_a.ex_pcload = 1'b1; bus_a.ex_flush = 1'b1; bus_a.ex_pc = 32'h24;
    expect_cyc(32'h88, 32'h84, word(32'h84), 1, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      bus_a.ex_flush = 1'b1; bus_a.ex_srcPC = 2'b01; bus_a.ex_branch_taken = 1'b1;
      bus_a.ex_target = 32'h200; bus_a.stall = i[0]; bus_a.ex_pcload = (i == 2);
      bus_a.ex_pc = 32'h300;
      expect_cyc(32'h88, 32'h0, NOP, 0, 0, 1, 0);
    end
    tick(); bus_a.resume = 1'b1; expect_cyc(32'h88, 32'h0, NOP, 0, 0, 1, 0);
    tick(); expect_cyc(32'h28, 32'h0, NOP, 0, 0, 0, 0);
    tick(); bus_a.resume = 1'b1; expect_cyc(32'h2C, 32'h28, word(32'h28), 1, 0, 0, 1);

    // halt again, then reset while halted; second DUT wraps after reset
    tick(); bus_a.ex_pcload = 1'b1; bus_a.ex_flush = 1'b1; bus_a.ex_pc = 32'h50;
    expect_cyc(32'h30, 32'h2C, word(32'h2C), 1, 1, 0, 1);
    tick(); rst = 1'b1; expect_cyc(32'h30, 32'h0, NOP, 0, 0, 1, 0);
    tick(); rst = 1'b0; expect_cyc(32'h00, 32'h0, NOP, 0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    tick(); expect_cyc(32'h04, 32'h00, word(32'h00), 1, 0, 0, 1, 1, 32'h0);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
